// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and counter sizing for rst_seq.
// Imported by the sequencer top.
package rst_seq_pkg;

    typedef logic [1:0] rs_state_t;

    localparam rs_state_t ST_SYNC    = 2'd0;
    localparam rs_state_t ST_STRETCH = 2'd1;
    localparam rs_state_t ST_RELEASE = 2'd2;
    localparam rs_state_t ST_RUN     = 2'd3;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: async-assert, sync-release reset synchroniser.
// rel_o marks the cycle in which the final stage is about to capture 1.
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic rel_o
);

    logic [STAGES-1:0] sync_q;

    // Shift a constant 1 in; the whole chain clears on arst_n low.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    // The sequencer leaves SYNC on the edge the last stage goes high,
    // so it looks one stage back and qualifies with the last stage.
    assign rel_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: synchronise arst_n, stretch, then release per-channel
// resets in index order, honouring per-channel holds and sw_rst.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 4,
    parameter int STEP_DLY    = 8
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            sw_rst,
    input  logic [N_CH-1:0] ch_hold,
    output logic [N_CH-1:0] rst_n,
    output logic            all_rdy,
    output logic [1:0]      state
);

    localparam int SW = cnt_w(STRETCH);
    localparam int DW = cnt_w(STEP_DLY);
    localparam int STEP_M1 = (STEP_DLY > 0) ? STEP_DLY - 1 : 0;
    localparam logic [SW-1:0] STR_LD  = SW'(STRETCH - 1);
    localparam logic [DW-1:0] STEP_LD = DW'(STEP_M1);

    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $fatal(1, "rst_seq: N_CH must be 1..8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $fatal(1, "rst_seq: SYNC_STAGES must be 2..4");
    end
    if (STRETCH < 1 || STRETCH > 255) begin : g_bad_str
        $fatal(1, "rst_seq: STRETCH must be 1..255");
    end
    if (STEP_DLY < 0 || STEP_DLY > 255) begin : g_bad_step
        $fatal(1, "rst_seq: STEP_DLY must be 0..255");
    end

    rs_state_t       state_q, state_d;
    logic [SW-1:0]   str_q, str_d;
    logic [DW-1:0]   step_q, step_d;
    logic [N_CH-1:0] rst_q, rst_d;
    logic            rdy_q, rdy_d;

    logic            sync_rel;
    logic            try_rel;
    logic            go;
    logic            fired;
    logic [N_CH-1:0] rel_vec;

    rst_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .rel_o  (sync_rel)
    );

    // Release attempt: walk pending channels in order, stop at a held
    // one; with STEP_DLY=0 every unheld pending channel goes at once.
    always_comb begin
        rel_vec = rst_q;
        fired   = 1'b0;
        go      = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (!rst_q[k] && go) begin
                if (ch_hold[k]) begin
                    go = 1'b0;
                end else begin
                    rel_vec[k] = 1'b1;
                    fired      = 1'b1;
                    if (STEP_DLY != 0) go = 1'b0;
                end
            end
        end
    end

    // Next state: count down, attempt releases, sw_rst overrides all.
    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        step_d  = step_q;
        rst_d   = rst_q;
        rdy_d   = rdy_q;
        try_rel = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (sync_rel) begin
                    state_d = ST_STRETCH;
                    str_d   = STR_LD;
                end
            end
            ST_STRETCH: begin
                if (str_q != '0) str_d = str_q - 1'b1;
                else             try_rel = 1'b1;
            end
            ST_RELEASE: begin
                if (step_q != '0) step_d = step_q - 1'b1;
                else              try_rel = 1'b1;
            end
            default: begin
            end
        endcase
        if (try_rel) begin
            rst_d   = rel_vec;
            rdy_d   = &rel_vec;
            step_d  = fired ? STEP_LD : '0;
            state_d = (&rel_vec) ? ST_RUN : ST_RELEASE;
        end
        if (sw_rst && state_q != ST_SYNC) begin
            rst_d   = '0;
            rdy_d   = 1'b0;
            state_d = ST_STRETCH;
            str_d   = STR_LD;
        end
    end

    // State, counters and outputs; all clear asynchronously.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_SYNC;
            str_q   <= '0;
            step_q  <= '0;
            rst_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            step_q  <= step_d;
            rst_q   <= rst_d;
            rdy_q   <= rdy_d;
        end
    end

    assign rst_n   = rst_q;
    assign all_rdy = rdy_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq, default and wide configs.
// Expected outputs come from an edge-time model of the release rules.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       sw_a, sw_b;
    logic [2:0] hold_a;
    logic [7:0] hold_b;
    logic [2:0] rn_a;
    logic [7:0] rn_b;
    logic       rdy_a, rdy_b;
    logic [1:0] st_a, st_b;

    always #5 clk = ~clk;

    rst_seq u_a (
        .clk     (clk),
        .arst_n  (arst_n),
        .sw_rst  (sw_a),
        .ch_hold (hold_a),
        .rst_n   (rn_a),
        .all_rdy (rdy_a),
        .state   (st_a)
    );

    rst_seq #(
        .N_CH        (8),
        .SYNC_STAGES (4),
        .STRETCH     (1),
        .STEP_DLY    (0)
    ) u_b (
        .clk     (clk),
        .arst_n  (arst_n),
        .sw_rst  (sw_b),
        .ch_hold (hold_b),
        .rst_n   (rn_b),
        .all_rdy (rdy_b),
        .state   (st_b)
    );

    typedef struct {
        int         e;
        logic [7:0] rn;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    int P_N[2]    = '{3, 8};
    int P_S[2]    = '{2, 4};
    int P_ST[2]   = '{4, 1};
    int P_STEP[2] = '{8, 0};

    // Model: edge count since reset, channels released, next release edge.
    int m_e[2];
    int m_rel[2];
    int m_pt[2];

    int         rise[2][9];
    logic [8:0] prev[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_e[i]   = 0;
            m_rel[i] = 0;
            m_pt[i]  = P_S[i] + P_ST[i];
            for (int b = 0; b < 9; b++) rise[i][b] = -1;
        end
    endtask

    task automatic model_edge(input int i, input bit sw,
                              input logic [7:0] hold, output exp_t x);
        m_e[i]++;
        if (sw && m_e[i] > P_S[i]) begin
            m_rel[i] = 0;
            m_pt[i]  = m_e[i] + P_ST[i];
        end else begin
            while (m_rel[i] < P_N[i] && m_e[i] >= m_pt[i]
                   && !hold[m_rel[i][2:0]]) begin
                m_rel[i]++;
                m_pt[i] = m_e[i] + P_STEP[i];
            end
        end
        x.e   = m_e[i];
        x.rn  = 8'((1 << m_rel[i]) - 1);
        x.rdy = (m_rel[i] == P_N[i]);
        if (m_e[i] < P_S[i])                          x.st = 2'd0;
        else if (m_rel[i] == P_N[i])                  x.st = 2'd3;
        else if (m_rel[i] == 0 && m_e[i] < m_pt[i])   x.st = 2'd1;
        else                                          x.st = 2'd2;
    endtask

    task automatic step(input bit swa, input logic [2:0] ha,
                        input bit swb, input logic [7:0] hb);
        exp_t x;
        sw_a   = swa;
        hold_a = ha;
        sw_b   = swb;
        hold_b = hb;
        model_edge(0, swa, {5'b0, ha}, x);
        q0.push_back(x);
        model_edge(1, swb, hb, x);
        q1.push_back(x);
        @(negedge clk);
    endtask

    task automatic apulse();
        #1 arst_n = 1'b0;
        #1;
        chk("async_rst_n_a", int'(rn_a), 0);
        chk("async_rdy_a", int'(rdy_a), 0);
        chk("async_state_a", int'(st_a), 0);
        chk("async_rst_n_b", int'(rn_b), 0);
        chk("async_rdy_b", int'(rdy_b), 0);
        #1 arst_n = 1'b1;
        model_reset();
    endtask

    task automatic mon_one(input int i, input logic [7:0] rn,
                           input logic rdy, input logic [1:0] st);
        exp_t       x;
        logic [8:0] cur;
        checks++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL sb_empty%0d: got output with no expectation", i);
        end else begin
            if (i == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            chk($sformatf("rst_n%0d@e%0d", i, x.e), int'(rn), int'(x.rn));
            chk($sformatf("all_rdy%0d@e%0d", i, x.e), int'(rdy), int'(x.rdy));
            chk($sformatf("state%0d@e%0d", i, x.e), int'(st), int'(x.st));
            cur = {rdy, rn};
            for (int b = 0; b < 9; b++) begin
                if (cur[b] && !prev[i][b]) rise[i][b] = x.e;
            end
            prev[i] = cur;
        end
    endtask

    // Monitor: compare DUT outputs just after each active edge.
    initial begin
        prev[0] = '0;
        prev[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                mon_one(0, {5'b0, rn_a}, rdy_a, st_a);
                mon_one(1, rn_b, rdy_b, st_b);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        bit         swa, swb;
        int         ba, bb;
        logic [2:0] ha;
        logic [7:0] hb;

        arst_n = 1'b0;
        sw_a   = 1'b0;
        sw_b   = 1'b0;
        hold_a = '0;
        hold_b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rst_n_a", int'(rn_a), 0);
        chk("reset_state_a", int'(st_a), 0);
        chk("reset_rst_n_b", int'(rn_b), 0);
        arst_n = 1'b1;
        mon_on = 1'b1;

        repeat (40) step(0, '0, 0, '0);
        chk("plain_ch0_edge", rise[0][0], 6);
        chk("plain_ch1_edge", rise[0][1], 14);
        chk("plain_ch2_edge", rise[0][2], 22);
        chk("plain_rdy_edge", rise[0][8], 22);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("wide_ch%0d_edge", b), rise[1][b], 5);
        end
        chk("wide_rdy_edge", rise[1][8], 5);

        apulse();
        for (int t = 1; t <= 125; t++) begin
            step(t == 100, (t <= 30) ? 3'b010 : 3'b000, 0, '0);
            if (t == 60) begin
                chk("hold_ch0_edge", rise[0][0], 6);
                chk("hold_ch1_edge", rise[0][1], 31);
                chk("hold_ch2_edge", rise[0][2], 39);
            end
        end
        chk("sw_ch0_edge", rise[0][0], 104);
        chk("sw_rdy_edge", rise[0][8], 120);

        apulse();
        repeat (10) step(0, '0, 0, '0);
        apulse();
        repeat (30) step(0, '0, 0, '0);
        chk("rearst_ch0_edge", rise[0][0], 6);
        chk("rearst_rdy_edge", rise[0][8], 22);

        apulse();
        for (int t = 1; t <= 50; t++) begin
            step(t >= 8 && t <= 17, '0, t >= 8 && t <= 17, '0);
        end
        chk("swhold_ch0_edge", rise[0][0], 21);
        chk("swhold_rdy_edge", rise[0][8], 37);
        chk("swhold_wide_rdy", rise[1][8], 18);

        apulse();
        ba = 0;
        bb = 0;
        ha = '0;
        hb = '0;
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(0, 299) == 0) apulse();
            if (ba == 0 && $urandom_range(0, 49) == 0) ba = $urandom_range(1, 4);
            if (bb == 0 && $urandom_range(0, 49) == 0) bb = $urandom_range(1, 4);
            swa = (ba != 0);
            swb = (bb != 0);
            if (ba != 0) ba--;
            if (bb != 0) bb--;
            if ($urandom_range(0, 7) == 0) ha = 3'($urandom);
            if ($urandom_range(0, 7) == 0) hb = 8'($urandom) & 8'($urandom);
            step(swa, ha, swb, hb);
        end

        mon_on = 1'b0;
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 3; number of reset outputs, legal range 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; reset synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter STRETCH, default 4; minimum cycles all outputs stay asserted after the synchronised reset releases, legal range 1..255.
REQ-004 SHALL have parameter STEP_DLY, default 8; cycles between successive channel releases, legal range 0..255.
REQ-005 SHALL have port clk, input, 1; system clock, all logic rising-edge.
REQ-006 SHALL have port arst_n, input, 1; reset, asynchronous, active-low.
REQ-007 SHALL have port sw_rst, input, 1; synchronous software reset request, active-high.
REQ-008 SHALL have port ch_hold, input, N_CH; per-channel hold-in-reset request, synchronous.
REQ-009 SHALL have port rst_n, output, N_CH; per-channel reset, active-low, registered.
REQ-010 SHALL have port all_rdy, output, 1; high when every rst_n bit is high.
REQ-011 SHALL have port state, output, 2; current sequencer state encoding.

Function
REQ-012 SHALL pass arst_n through a SYNC_STAGES flop chain; chain input is constant 1, all flops clear asynchronously on arst_n low.
REQ-013 SHALL implement states SYNC=0, STRETCH=1, RELEASE=2, RUN=3.
REQ-014 SHALL transition from SYNC to STRETCH on the edge where the synchroniser output is first sampled high, loading the stretch counter with STRETCH-1.
REQ-015 SHALL hold STRETCH until the counter reaches 0, then enter RELEASE and drive rst_n[0] high on that same edge.
REQ-016 SHALL release channels strictly in index order, rst_n[k] rising STEP_DLY edges after rst_n[k-1]; STEP_DLY=0 releases all channels on the same edge.
REQ-017 SHALL, counting the first rising edge with arst_n high as edge 1, raise rst_n[k] at edge SYNC_STAGES+STRETCH+k*STEP_DLY when no hold or sw_rst occurs.
REQ-018 SHALL, while ch_hold[k]=1 at the release point of channel k, keep rst_n[k] low and stall the sequence; channel k rises on the edge after ch_hold[k] is sampled 0, and the STEP_DLY count to k+1 restarts from that edge.
REQ-019 SHALL ignore ch_hold for channels already released, and for all channels in state RUN.
REQ-020 SHALL enter RUN on the edge the last channel is released; all_rdy rises on that same edge.
REQ-021 SHALL, when sw_rst is sampled 1 in any state except SYNC, drive all rst_n low and all_rdy low on that edge, enter STRETCH, and reload the stretch counter; the synchroniser is not re-run.
REQ-022 SHALL keep reloading the stretch counter while sw_rst stays 1, so release begins STRETCH edges after the last edge where sw_rst is sampled 1.
REQ-023 SHALL ignore sw_rst in state SYNC.
REQ-024 SHALL size the stretch and step counters with $clog2 of their maximum value plus 1, and SHALL NOT wrap them.
REQ-025 SHALL make every output a direct flop output, with no combinational path from any input to any output.

Reset
REQ-026 SHALL, on arst_n low, asynchronously and immediately set rst_n to all 0, all_rdy to 0, state to SYNC, counters to 0 and the synchroniser to all 0, in any state including mid-RELEASE.
REQ-027 SHALL generate every deassertion of rst_n synchronously to clk.

Structure
REQ-028 SHALL place the state encoding type and the state constants in shared package rst_seq_pkg.
REQ-029 SHALL implement the synchroniser as sub-module rst_sync_chain, parametrised by SYNC_STAGES.
REQ-030 SHALL check parameter ranges at elaboration and raise a fatal error on an illegal value.

Verification
REQ-031 Defaults, arst_n released, no hold -> rst_n[0] rises at edge 6, rst_n[1] at edge 14, rst_n[2] at edge 22; all_rdy and state=3 at edge 22.
REQ-032 Defaults, ch_hold[1]=1 until edge 30 then 0 -> rst_n[1] rises at edge 31, rst_n[2] at edge 39; rst_n[0] unaffected at edge 6.
REQ-033 In RUN, 1-cycle sw_rst at edge 100 -> rst_n=000 and state=1 at edge 100, rst_n[0] rises at edge 104, all_rdy at edge 120.
REQ-034 arst_n pulsed low mid-RELEASE, between edges 10 and 11 -> rst_n=000 immediately, without waiting for a clock edge; the full sequence restarts per REQ-017.
REQ-035 STEP_DLY=0, N_CH=8, SYNC_STAGES=4, STRETCH=1 -> all eight rst_n and all_rdy rise together at edge 5.
REQ-036 sw_rst held high for 10 cycles in RELEASE -> outputs stay 0; rst_n[0] rises STRETCH edges after the last sampled-high edge.
